// File: rtl/nn_pkg.sv
// Shared widths, decode field positions and the fetch-to-decode payload type.
package nn_pkg;

    localparam int unsigned INSTR_W = 12;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned PC_W    = 32;

    localparam int unsigned OP_MSB    = 11;
    localparam int unsigned OP_LSB    = 8;
    localparam int unsigned DENSE_MSB = 7;
    localparam int unsigned DENSE_LSB = 4;
    localparam int unsigned ACT_MSB   = 3;
    localparam int unsigned ACT_LSB   = 0;
    localparam int unsigned COST_MSB  = 7;
    localparam int unsigned COST_LSB  = 0;

    typedef struct packed {
        logic [PC_W-1:0]    index;
        logic [INSTR_W-1:0] instr;
    } fd_reg_t;

endpackage

// File: rtl/code_storage.sv
// Program store: one synchronous write port, one combinational read port.
// A same-cycle write and read to one address returns the old word.
module code_storage
    import nn_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data_c
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the program survives any reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read feeds the fetch stage directly.
    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/nn_data_path.sv
// Instruction front end: code storage, sequential fetch, F/D register, field decode.
module nn_data_path
    import nn_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               code_storage_write_interface_is_write,
    input  logic [PC_W-1:0]    code_storage_write_interface_write_line,
    input  logic [INSTR_W-1:0] code_storage_write_interface_write_data,
    input  logic               code_storage_code_control_interface_reset,
    input  logic               code_storage_code_control_interface_active,
    output logic [PC_W-1:0]    fetch_to_decode_register_code_index_out_interface_code_index,
    output logic [OP_W-1:0]    parse_op_interface_op,
    output logic [3:0]         parse_parameter_type_interface_act_type,
    output logic [3:0]         parse_parameter_type_interface_dense_type,
    output logic [7:0]         parse_parameter_type_interface_cost_type
);

    logic [PC_W-1:0]    pc_q;
    fd_reg_t            fd_q;
    logic [INSTR_W-1:0] fetch_word_c;
    logic               wr_en_c;

    // Out-of-range lines are dropped rather than aliased onto low addresses.
    assign wr_en_c = code_storage_write_interface_is_write &&
                     (code_storage_write_interface_write_line < PC_W'(DEPTH));

    code_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_code_storage (
        .clk       (clk_clk),
        .wr_en     (wr_en_c),
        .wr_addr   (code_storage_write_interface_write_line[AW-1:0]),
        .wr_data   (code_storage_write_interface_write_data),
        .rd_addr   (pc_q[AW-1:0]),
        .rd_data_c (fetch_word_c)
    );

    // Program counter and F/D register; either reset source beats a fetch.
    always_ff @(posedge clk_clk) begin
        if (reset_reset_n || code_storage_code_control_interface_reset) begin
            pc_q <= '0;
            fd_q <= '0;
        end else if (code_storage_code_control_interface_active) begin
            fd_q.index <= pc_q;
            fd_q.instr <= fetch_word_c;
            pc_q       <= pc_q + PC_W'(1);
        end
    end

    // Decode is pure field slicing of the held word; later stages qualify by op.
    assign fetch_to_decode_register_code_index_out_interface_code_index = fd_q.index;
    assign parse_op_interface_op                     = fd_q.instr[OP_MSB:OP_LSB];
    assign parse_parameter_type_interface_dense_type = fd_q.instr[DENSE_MSB:DENSE_LSB];
    assign parse_parameter_type_interface_act_type   = fd_q.instr[ACT_MSB:ACT_LSB];
    assign parse_parameter_type_interface_cost_type  = fd_q.instr[COST_MSB:COST_LSB];

endmodule

// File: tb/tb_nn_data_path.sv
// Self-checking bench for nn_data_path against a transaction-level program model.
module tb_nn_data_path;

    logic        clk;
    logic        rst;
    logic        is_write;
    logic [31:0] write_line;
    logic [11:0] write_data;
    logic        ctrl_reset;
    logic        active;
    logic [31:0] code_index;
    logic [3:0]  op;
    logic [3:0]  act_type;
    logic [3:0]  dense_type;
    logic [7:0]  cost_type;

    logic [51:0] obs;
    assign obs = {code_index, op, dense_type, act_type, cost_type};

    // Program model: storage contents, fetch pointer, and word held in decode.
    logic [11:0] m_mem [256];
    logic [31:0] m_pc;
    logic [31:0] m_idx;
    logic [11:0] m_instr;

    int errors = 0;
    int checks = 0;

    nn_data_path dut (
        .clk_clk                                   (clk),
        .reset_reset_n                             (rst),
        .code_storage_write_interface_is_write     (is_write),
        .code_storage_write_interface_write_line   (write_line),
        .code_storage_write_interface_write_data   (write_data),
        .code_storage_code_control_interface_reset (ctrl_reset),
        .code_storage_code_control_interface_active(active),
        .fetch_to_decode_register_code_index_out_interface_code_index(code_index),
        .parse_op_interface_op                     (op),
        .parse_parameter_type_interface_act_type   (act_type),
        .parse_parameter_type_interface_dense_type (dense_type),
        .parse_parameter_type_interface_cost_type  (cost_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle derived from the modelled decode-stage word.
    function automatic logic [51:0] exp_out();
        return {m_idx, m_instr[11:8], m_instr[7:4], m_instr[3:0], m_instr[7:0]};
    endfunction

    // Apply one cycle of inputs, advance the model by the documented priority rules.
    task automatic step(input logic r, input logic we, input logic [31:0] line,
                        input logic [11:0] data, input logic cr, input logic act);
        logic [11:0] fetched;
        @(negedge clk);
        rst = r; is_write = we; write_line = line; write_data = data;
        ctrl_reset = cr; active = act;
        @(posedge clk);
        fetched = m_mem[m_pc % 256];
        if (r || cr) begin
            m_pc = 0; m_idx = 0; m_instr = 0;
        end else if (act) begin
            m_idx = m_pc; m_instr = fetched; m_pc = m_pc + 32'd1;
        end
        if (we && line < 32'd256) m_mem[line % 256] = data;
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 52'd0) begin
            errors++; $display("FAIL reset: got %h expected %h", obs, 52'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== 52'd0) begin
                errors++; $display("FAIL reset_hold%0d: got %h expected %h", i, obs, 52'd0);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) step(0, 1, 32'(i), 12'($urandom), 0, 0);
        checks++;
        if (obs !== 52'd0) begin
            errors++; $display("FAIL fill_idle: got %h expected %h", obs, 52'd0);
        end
    endtask

    task automatic test_seq_fetch();
        logic [51:0] lit [4];
        lit[0] = {32'd0, 4'h1, 4'hA, 4'h5, 8'hA5};
        lit[1] = {32'd1, 4'h2, 4'hF, 4'h0, 8'hF0};
        lit[2] = {32'd2, 4'h3, 4'h0, 4'hC, 8'h0C};
        lit[3] = {32'd3, 4'hF, 4'h8, 4'h1, 8'h81};
        step(0, 1, 0, 12'h1A5, 0, 0);
        step(0, 1, 1, 12'h2F0, 0, 0);
        step(0, 1, 2, 12'h30C, 0, 0);
        step(0, 1, 3, 12'hF81, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== lit[i]) begin
                errors++; $display("FAIL seq_fetch%0d: got %h expected %h", i, obs, lit[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [51:0] held;
        held = {32'd2, 4'h3, 4'h0, 4'hC, 8'h0C};
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== held) begin
                errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, held);
            end
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== {32'd3, 4'hF, 4'h8, 4'h1, 8'h81}) begin
            errors++; $display("FAIL stall_resume: got %h expected %h", obs,
                               {32'd3, 4'hF, 4'h8, 4'h1, 8'h81});
        end
    endtask

    task automatic test_ctrl_reset_mid_run();
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (obs !== 52'd0) begin
            errors++; $display("FAIL ctrl_reset_clear: got %h expected %h", obs, 52'd0);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (code_index !== 32'd0 || op !== 4'h1) begin
            errors++; $display("FAIL ctrl_reset_restart: got idx %0d op %h expected idx 0 op 1",
                               code_index, op);
        end
    endtask

    task automatic test_collision_and_range();
        logic [11:0] old5;
        logic [11:0] old44;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        old5 = m_mem[5];
        step(0, 1, 5, 12'h777, 0, 1);
        checks++;
        if (code_index !== 32'd5 || {op, dense_type, act_type} !== old5) begin
            errors++; $display("FAIL collision_old: got idx %0d word %h expected idx 5 word %h",
                               code_index, {op, dense_type, act_type}, old5);
        end
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        checks++;
        if (code_index !== 32'd5 || op !== 4'h7) begin
            errors++; $display("FAIL collision_new: got idx %0d op %h expected idx 5 op 7",
                               code_index, op);
        end
        old44 = m_mem[44];
        step(0, 1, 300, ~old44, 0, 0);
        step(0, 1, 256, ~m_mem[0], 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 45; i++) step(0, 0, 0, 0, 0, 1);
        checks++;
        if (code_index !== 32'd44 || {op, dense_type, act_type} !== old44) begin
            errors++; $display("FAIL out_of_range: got idx %0d word %h expected idx 44 word %h",
                               code_index, {op, dense_type, act_type}, old44);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] w0;
        w0 = m_mem[0];
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 257; i++) begin
            step(0, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL wrap_run%0d: got %h expected %h", i, obs, exp_out());
            end
        end
        checks++;
        if (code_index !== 32'd256 || {op, dense_type, act_type} !== w0) begin
            errors++; $display("FAIL wrap_256: got idx %0d word %h expected idx 256 word %h",
                               code_index, {op, dense_type, act_type}, w0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r, we, cr, act;
            logic [31:0] line;
            r    = ($urandom_range(0, 39) == 0);
            cr   = ($urandom_range(0, 29) == 0);
            we   = ($urandom_range(0, 2) == 0);
            act  = ($urandom_range(0, 3) != 0);
            line = ($urandom_range(0, 1) == 0) ? 32'(m_pc % 256) : 32'($urandom_range(0, 299));
            step(r, we, line, 12'($urandom), cr, act);
            checks++;
            if (obs !== exp_out()) begin
                errors++; $display("FAIL random%0d: got %h expected %h", i, obs, exp_out());
            end
        end
    endtask

    initial begin
        rst = 1'b1; is_write = 1'b0; write_line = '0; write_data = '0;
        ctrl_reset = 1'b0; active = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_pc = 0; m_idx = 0; m_instr = 0;
        test_reset();
        test_fill();
        test_seq_fetch();
        test_stall();
        test_ctrl_reset_mid_run();
        test_collision_and_range();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nn_data_path.md
# nn_data_path

Front end of the neural-network instruction pipeline. Holds a writable 12-bit program in a code storage, fetches sequentially under code-control signals, latches each fetched word with its index in a fetch-to-decode register, and decodes the opcode and parameter-type fields for the execution stages. The top-level module name is `nn_data_path`; it replaces the former `data_path` top.

## Interface
- `DEPTH`, 256: code storage words; power of two.
- `AW`, 8: storage address width, log2(DEPTH).
- `clk_clk` in 1: single clock; all state updates on the rising edge.
- `reset_reset_n` in 1: synchronous, active-high reset, despite the `_n` suffix.
- `code_storage_write_interface_is_write` in 1: write strobe.
- `code_storage_write_interface_write_line` in 32: write address.
- `code_storage_write_interface_write_data` in 12: instruction word to write.
- `code_storage_code_control_interface_reset` in 1: restarts the program at index 0.
- `code_storage_code_control_interface_active` in 1: run enable for fetch.
- `fetch_to_decode_register_code_index_out_interface_code_index` out 32: index of the word held in the decode stage.
- `parse_op_interface_op` out 4: opcode.
- `parse_parameter_type_interface_act_type` out 4: activation type.
- `parse_parameter_type_interface_dense_type` out 4: dense-layer type.
- `parse_parameter_type_interface_cost_type` out 8: cost type.

## Operation
- **Storage write**
  - When `is_write`=1 at an edge, `mem[write_line[AW-1:0]] <= write_data`, but only if `write_line < DEPTH`.
  - Out-of-range writes are ignored.
  - Memory contents are not cleared by either reset.
- **Fetch**
  - The 32-bit program counter `pc` addresses the storage with `pc[AW-1:0]`.
  - The storage read is combinational.
  - A write and a fetch to the same address in the same cycle: the fetch returns the old data.
- **Update priority, per edge**
  1. `reset_reset_n`: `pc`=0 and the F/D register is cleared (index 0, instruction 0).
  2. Otherwise `control_reset`: same effect as `reset_reset_n`.
  3. Otherwise `active`=1: the F/D register loads {`pc`, `mem[pc]`}, then `pc <= pc+1`.
  4. Otherwise: `pc` and the F/D register hold.
- **`pc` wrap**
  - `pc` wraps modulo 2^32.
  - The address wraps modulo DEPTH, so fetch continues from word 0 after DEPTH-1.
- **Decode** is combinational from the F/D register, with `instr` = its 12-bit word:
  - `op` = `instr[11:8]`.
  - `dense_type` = `instr[7:4]`.
  - `act_type` = `instr[3:0]`.
  - `cost_type` = `instr[7:0]`.
  - All fields are presented regardless of opcode; later stages qualify them by `op`.
- **Code index output:** `code_index` = F/D register index.

## Timing
- Reset value of all outputs is 0, valid in the cycle after the reset edge.
- Fetch latency: with `active` high at edge n and `pc`=k, the outputs show index k and the decode of `mem[k]` after edge n. This is one cycle of latency; throughput is one word per cycle.
- Write-to-fetch: a word written at edge n is fetchable from edge n+1.
- Deasserting `active` freezes the outputs on their last values.
- Reasserting `active` resumes from the held `pc` with no skipped or repeated index.
- A reset or `control_reset` asserted mid-run wins over `active` and over the F/D load in the same cycle.
- A write in the same cycle as a reset still takes effect.

## Structure
- Shared package `nn_pkg`:
  - `INSTR_W`=12, `OP_W`=4, `PC_W`=32.
  - Field slice constants: OP_MSB/LSB=11/8, DENSE 7/4, ACT 3/0, COST 7/0.
  - Packed struct `fd_reg_t` {index[31:0], instr[11:0]}.
- Sub-module `code_storage`: a DEPTH×12 array with one write port and one combinational read port.
- Everything else stays in the top:
  - `pc` register.
  - F/D register.
  - Decode slicing.

## Test plan
- **Reset:** hold `reset_reset_n`=1 for 2 cycles, then 0 with `active`=0 -> all outputs 0 and stay 0.
- **Sequential fetch:**
  - Stimulus: write lines 0..3 = 12'h1A5, 12'h2F0, 12'h30C, 12'hF81, then `control_reset` 1 cycle, then `active`=1.
  - Response, on successive cycles:
    - index 0, `op`=1, `dense`=A, `act`=5, `cost`=A5.
    - index 1, `op`=2, `cost`=F0.
    - index 2, `op`=3, `act`=C.
    - index 3, `op`=F, `cost`=81.
- **Stall:**
  - Stimulus: `active`=0 for 3 cycles at index 2, then 1.
  - Response: outputs hold index 2/`op` 3, then index 3 follows with no skip.
- **Control reset mid-run:**
  - Stimulus: `control_reset`=1 with `active`=1 while at index 3.
  - Response: next cycle index 0 with `instr` 0; after that, index 0 with `op`=1.
- **Write/fetch collision and out-of-range:**
  - Collision: write line 5 = 12'h777 in the cycle `pc`=5 -> index 5 shows the old word. After `pc` returns to 5 via `control_reset` -> `op`=7.
  - Out-of-range: a write to line 300 (DEPTH 256) -> no storage word changes; line 44 is untouched.
- **Wrap:**
  - Stimulus: run 257 active cycles after `control_reset`.
  - Response: index 256 shows `mem[0]`'s decode.
